nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that performs one WIDTH-bit add by driving a single external 4-bit ripple adder
//  for WIDTH/4 cycles, one nibble per cycle, LSB first, with the carry registered between
//  cycles. Sits between a valid/ready operand source and a valid/ready result sink.
//  Trades latency for reuse of one small adder datapath.
// PARAMETERS
//  WIDTH  16  operand/result width; multiple of 4, >= 4. Derived: NIB = WIDTH/4.
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      operand request valid
//  in_ready    out  1      operand accept; high only in IDLE
//  in_a        in   WIDTH  operand A
//  in_b        in   WIDTH  operand B
//  in_cin      in   1      carry-in for nibble 0
//  in_sub      in   1      subtract request (see CONFIGURATION)
//  out_valid   out  1      result valid
//  out_ready   in   1      result accept
//  out_sum     out  WIDTH  result
//  out_cout    out  1      carry out of top nibble
//  busy        out  1      high in RUN or DONE
//  adder_a     out  4      nibble of A to adder
//  adder_b     out  4      nibble of B to adder
//  adder_cin   out  1      carry to adder
//  adder_s     in   4      adder sum (combinational from adder_*)
//  adder_cout  in   1      adder carry out
// BEHAVIOUR
//  - FSM states: IDLE, RUN, DONE. Registers: op_a, op_b, carry, idx (clog2(NIB) bits, min 1), sum.
//  - Reset (async, rst_n=0): state=IDLE, idx=0, carry=0, sum=0, out_cout=0, out_valid=0, busy=0,
//    adder_a/adder_b/adder_cin=0. in_ready=1 whenever state==IDLE, including during reset.
//  - IDLE: in_ready=1. On in_valid&in_ready: capture in_a, in_b, and carry<=in_cin; idx<=0; go to RUN.
//  - RUN: adder_a=op_a[4*idx+:4], adder_b=op_b[4*idx+:4], adder_cin=carry (combinational).
//    Each cycle: sum[4*idx+:4]<=adder_s; carry<=adder_cout; idx<=idx+1.
//    When idx==NIB-1: out_cout<=adder_cout; go to DONE.
//  - DONE: out_valid=1; out_sum=sum; out_cout held. On out_ready: go to IDLE. in_ready=0.
//  - Latency: accept at edge T -> RUN for NIB cycles -> out_valid high from cycle T+NIB+1.
//    For WIDTH=4: one RUN cycle.
//  - No overlap: a new operand is not accepted until the result handshake completes.
//    Throughput is one op per NIB+2 cycles with out_ready tied high.
//  - Outside RUN: adder_a, adder_b and adder_cin are driven 0.
//  - DONE backpressure: out_valid, out_sum and out_cout stay stable until out_ready.
//  - in_a/in_b/in_cin changes after acceptance have no effect.
//  - Reset mid-RUN or mid-DONE: operation is discarded; no out_valid pulse. Arithmetic is
//    modulo 2^WIDTH; the carry chain spans all nibbles unbroken.
// CONFIGURATION
//  NSA_SUB_EN defined:
//    - in_sub is captured on accept.
//    - If in_sub=1: op_b<=~in_b and carry<=1 (in_cin ignored). out_sum=A-B mod 2^WIDTH.
//    - out_cout=1 means no borrow (A>=B).
//  NSA_SUB_EN undefined: in_sub is ignored (treated 0); add only. Port list is unchanged.
// TESTING (WIDTH=16)
//  1. A=0x1234, B=0x0FCD, cin=0 -> out_valid 5 cycles after accept; sum=0x2201, cout=0.
//  2. A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, cout=1; adder_cin=1 on nibbles 1..3.
//  3. A=0x0000, B=0x0000, cin=1 -> sum=0x0001, cout=0.
//  4. out_ready=0 for 5 cycles in DONE -> out_valid/out_sum/out_cout hold, in_ready=0 throughout;
//     then out_ready=1 -> IDLE next cycle.
//  5. rst_n low during RUN idx=2 -> all outputs at reset values, no out_valid;
//     next op 0x0001+0x0001 -> 0x0002.
//  6. NSA_SUB_EN, in_sub=1: 0x0005-0x0007 -> sum=0xFFFE, cout=0; 0x0007-0x0005 -> 0x0002, cout=1.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer that runs one WIDTH-bit add through an external 4-bit adder, one nibble per cycle, LSB first.
// Optional feature: define NSA_SUB_EN to enable subtraction (A - B) via in_sub.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy,
  output logic [3:0]       adder_a,
  output logic [3:0]       adder_b,
  output logic             adder_cin,
  input  logic [3:0]       adder_s,
  input  logic             adder_cout
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             sub_req;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] b_capt;
  logic             cin_capt;

`ifdef NSA_SUB_EN
  assign sub_req = in_sub;
`else
  logic unused_sub;
  assign unused_sub = in_sub;
  assign sub_req    = 1'b0;
`endif

  // Subtraction is A + ~B + 1, so the inversion and forced carry happen at capture time.
  assign b_capt   = sub_req ? ~in_b : in_b;
  assign cin_capt = sub_req ? 1'b1 : in_cin;
  assign accept   = in_valid & in_ready;
  assign last     = (idx == IW'(NIB - 1));
  assign out_sum  = sum;

  always_comb begin
    adder_a   = 4'h0;
    adder_b   = 4'h0;
    adder_cin = 1'b0;
    if (state == RUN) begin
      for (int n = 0; n < NIB; n++) begin
        if (idx == IW'(n)) begin
          adder_a = op_a[4*n +: 4];
          adder_b = op_b[4*n +: 4];
        end
      end
      adder_cin = carry;
    end
  end

  // Operand holding registers: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= in_a;
      op_b <= b_capt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry    <= cin_capt;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < NIB; n++) begin
            if (idx == IW'(n)) sum[4*n +: 4] <= adder_s;
          end
          carry <= adder_cout;
          idx   <= idx + 1'b1;
          if (last) begin
            out_cout  <= adder_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16) with a behavioural 4-bit adder and
// an arithmetic reference model; subtraction cases are exercised when NSA_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             in_cin, in_sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout, busy;
  logic [3:0]       adder_a, adder_b, adder_s;
  logic             adder_cin, adder_cout;

  int checks = 0;
  int errors = 0;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_s(adder_s), .adder_cout(adder_cout)
  );

  // External 4-bit ripple adder, purely combinational.
  assign {adder_cout, adder_s} = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0, adder_cin};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_out_sum"},   32'(out_sum), 32'd0);
    chk({tag, "_out_cout"},  32'(out_cout), 32'd0);
    chk({tag, "_adder"},     32'({adder_a, adder_b, adder_cin}), 32'd0);
  endtask

  // One complete operation; hold = cycles of out_ready=0 in DONE before acceptance.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input int hold);
    logic [15:0] bb;
    logic        c0;
    int unsigned full, mask, t, cy, exp9;
    int          waited;
    bb = b;
    c0 = cin;
`ifdef NSA_SUB_EN
    if (sub) begin
      bb = ~b;
      c0 = 1'b1;
    end
`endif
    full = 32'(a) + 32'(bb) + 32'(c0);

    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom);
    in_cin = 1'($urandom); in_sub = 1'($urandom);

    for (int i = 0; i < NIB; i++) begin
      mask = (32'd1 << (4 * i)) - 32'd1;
      t    = (32'(a) & mask) + (32'(bb) & mask) + 32'(c0);
      cy   = (t >> (4 * i)) & 32'd1;
      exp9 = (((32'(a) >> (4 * i)) & 32'hF) << 5) | (((32'(bb) >> (4 * i)) & 32'hF) << 1) | cy;
      chk($sformatf("run%0d_adder", i), 32'({adder_a, adder_b, adder_cin}), exp9);
      chk($sformatf("run%0d_ctrl", i), 32'({out_valid, busy, in_ready}), 32'b010);
      @(negedge clk);
    end

    // Accept edge plus NIB RUN edges: out_valid is visible NIB+1 edges after the accept edge began.
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) begin
      chk("timeout_out_valid", 32'(out_valid), 32'd1);
      return;
    end

    chk("sum",  32'(out_sum), full & 32'hFFFF);
    chk("cout", 32'(out_cout), (full >> 16) & 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_state", 32'({out_valid, busy, in_ready, out_cout, out_sum}),
          {16'd0, 3'b110, 1'((full >> 16) & 32'd1), 16'(full)});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("back_to_idle", 32'({out_valid, busy, in_ready}), 32'b001);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 5);

    // Reset in the middle of RUN: operation discarded.
    @(negedge clk);
    in_a = 16'h8888; in_b = 16'h8888; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NIB + 2; k++) begin
      @(negedge clk);
      chk("post_reset_no_valid", 32'(out_valid), 32'd0);
    end
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

`ifdef NSA_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1);
`endif

    for (int r = 0; r < 40; r++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
